// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: fixed-address I2C slave on the system clock domain.
// The first data byte of a write sets the register pointer. Later write
// bytes store at the pointer and auto-increment it. Reads return bytes from
// the pointer and auto-increment it. A side port preloads the register file
// and reports stored bus writes. There is no clock stretching.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h22,
  parameter int         ADDR_W     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe_o,
  input  logic              ld_en_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [7:0]        ld_data_i,
  output logic              wr_valid_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  state_t            r_state, w_state_nxt;
  logic              r_scl_s1, r_scl_s2, r_scl_d;
  logic              r_sda_s1, r_sda_s2, r_sda_d;
  logic [2:0]        r_bitcnt;
  logic [7:0]        r_shift;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_first, r_rw, r_busy, r_sda_oe;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_sda, w_last;
  logic       w_oe_nxt, w_mem_we;
  logic [7:0] w_byte, w_rd_byte;

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
      {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  // START and STOP need SCL high on both samples, so they never coincide
  // with an SCL edge.
  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
  assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
  assign w_sda      = r_sda_s2;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_last     = (r_bitcnt == 3'd7);
  assign w_rd_byte  = r_mem[r_ptr];
  assign w_mem_we   = ~rst_i & w_scl_rise & (r_state == S_WR_BYTE) & w_last & ~r_first;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: bus conditions override everything, otherwise advance on SCL rise.
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop)       w_state_nxt = S_IDLE;
    else if (w_start) w_state_nxt = S_ADDR;
    else if (w_scl_rise) begin
      case (r_state)
        S_ADDR:     if (w_last) w_state_nxt = (r_shift[6:0] == SLAVE_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK: w_state_nxt = r_rw ? S_RD_BYTE : S_WR_BYTE;
        S_WR_BYTE:  if (w_last) w_state_nxt = S_WR_ACK;
        S_WR_ACK:   w_state_nxt = S_WR_BYTE;
        S_RD_BYTE:  if (w_last) w_state_nxt = S_RD_ACK;
        S_RD_ACK:   w_state_nxt = w_sda ? S_WAIT_STOP : S_RD_BYTE;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  // SDA drive level to apply at the next SCL fall. A read byte's MSB comes
  // straight from memory on the first fall, when the shifter is loaded.
  always_comb begin
    w_oe_nxt = 1'b0;
    case (r_state)
      S_ADDR_ACK, S_WR_ACK: w_oe_nxt = 1'b1;
      S_RD_BYTE: w_oe_nxt = (r_bitcnt == 3'd0) ? ~w_rd_byte[7] : ~r_shift[3'd7 - r_bitcnt];
      default:   w_oe_nxt = 1'b0;
    endcase
  end

  // Datapath: bit counter, shifter, pointer, SDA drive and write reporting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_first    <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_scl_fall) r_sda_oe <= w_oe_nxt;
      if (w_scl_fall && r_state == S_RD_BYTE && r_bitcnt == 3'd0) r_shift <= w_rd_byte;
      if (w_stop) begin
        r_busy <= 1'b0;
      end else if (w_start) begin
        r_busy   <= 1'b1;
        r_bitcnt <= '0;
        r_first  <= 1'b1;
      end else if (w_scl_rise) begin
        case (r_state)
          S_ADDR: begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_last) r_rw <= w_sda;
          end
          S_WR_BYTE: begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_last) begin
              if (r_first) begin
                r_ptr   <= w_byte[ADDR_W-1:0];
                r_first <= 1'b0;
              end else begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_ptr;
                r_wr_data  <= w_byte;
                r_ptr      <= r_ptr + PTR_ONE;
              end
            end
          end
          S_RD_BYTE: begin
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_last) r_ptr <= r_ptr + PTR_ONE;
          end
          default: r_bitcnt <= '0;
        endcase
      end
    end
  end

  // Register file; the bus write is assigned last so it wins a same-address collision.
  always_ff @(posedge clk_i) begin
    if (ld_en_i)  r_mem[ld_addr_i] <= ld_data_i;
    if (w_mem_we) r_mem[r_ptr]     <= w_byte;
  end

  assign sda_oe_o   = r_sda_oe;
  assign wr_valid_o = r_wr_valid;
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;
  assign busy_o     = r_busy;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Scoreboard bench for i2c_slave_responder: a bit-banged master drives the
// wired-AND bus, expected bytes/acks/writes are queued up front and a monitor
// compares them as the DUT presents them.
module tb_i2c_slave_responder;
  localparam int T = 10;

  logic       clk = 1'b0, rst = 1'b1;
  logic       m_scl = 1'b1, m_sda = 1'b1;
  logic       ld_en = 1'b0;
  logic [3:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       sda_oe, wr_valid, busy, sda_line;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int    n_checks = 0, n_fail = 0;
  int    exp_wr[$];
  int    exp_bus[$];
  string exp_tag[$];
  int    obs_bus[$];
  int    mon_o, mon_e;
  string mon_t;

  assign sda_line = m_sda & ~sda_oe;

  i2c_slave_responder #(.SLAVE_ADDR(7'h22), .ADDR_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(m_scl), .sda_i(sda_line), .sda_oe_o(sda_oe),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Monitor: compare reported writes and bus observations against the queues.
  always @(negedge clk) begin
    if (wr_valid) begin
      if (exp_wr.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_addr_data", int'({wr_addr, wr_data}), mon_e);
      end
    end
    if (obs_bus.size() != 0) begin
      mon_o = obs_bus.pop_front();
      if (exp_bus.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL bus_unexpected: got 0x%0h, expected nothing", mon_o);
      end else begin
        mon_e = exp_bus.pop_front();
        mon_t = exp_tag.pop_front();
        chk(mon_t, mon_o, mon_e);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic wc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    wc(1);
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  // One master-driven bit; 'collide' fires ld_en into address 5 in the cycle
  // the slave stores the byte (two cycles after the pin rise reaches the DUT).
  task automatic bit_out(input logic b, input bit collide);
    m_sda = b; wc(T);
    m_scl = 1'b1;
    if (collide) begin
      wc(2); ld_en = 1'b1; ld_addr = 4'd5; ld_data = 8'hEE;
      wc(1); ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      wc(T - 3);
    end else wc(T);
    m_scl = 1'b0; wc(2);
  endtask

  task automatic bit_in(output logic v);
    m_sda = 1'b1; wc(T);
    m_scl = 1'b1; wc(T/2);
    v = sda_line; wc(T/2);
    m_scl = 1'b0; wc(2);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wc(T);
    m_scl = 1'b1; wc(T);
    m_sda = 1'b0; wc(T);
    m_scl = 1'b0; wc(2);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wc(T);
    m_scl = 1'b1; wc(T);
    m_sda = 1'b1; wc(T);
  endtask

  task automatic wbyte(input logic [7:0] b, input int exp_ack, input bit collide);
    logic a;
    exp_bus.push_back(exp_ack);
    exp_tag.push_back($sformatf("ack_of_%02h", b));
    for (int i = 7; i >= 0; i--) bit_out(b[i], collide && i == 0);
    bit_in(a);
    obs_bus.push_back(int'(a));
  endtask

  task automatic rbyte(input logic [7:0] exp, input logic mack);
    logic [7:0] v;
    logic       bv;
    exp_bus.push_back(int'(exp));
    exp_tag.push_back("read_byte");
    for (int i = 7; i >= 0; i--) begin bit_in(bv); v[i] = bv; end
    obs_bus.push_back(int'(v));
    bit_out(mack, 1'b0);
  endtask

  initial begin
    logic bv;
    // Reset state
    wc(5);
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_wr_valid", int'(wr_valid), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0; wc(5);

    // Write pointer 3, then A5, 5A
    exp_wr.push_back('h3A5); exp_wr.push_back('h45A);
    i2c_start();
    chk("busy_after_start", int'(busy), 1);
    wbyte(8'h44, 0, 0); wbyte(8'h03, 0, 0); wbyte(8'hA5, 0, 0); wbyte(8'h5A, 0, 0);
    i2c_stop();
    chk("busy_after_stop", int'(busy), 0);

    // Read back through a repeated START
    i2c_start();
    wbyte(8'h44, 0, 0); wbyte(8'h03, 0, 0);
    i2c_start();
    wbyte(8'h45, 0, 0);
    rbyte(8'hA5, 1'b0); rbyte(8'h5A, 1'b1);
    i2c_stop();

    // Address mismatch: NACK, busy held until STOP
    i2c_start();
    wbyte(8'h46, 1, 0);
    chk("busy_mismatch", int'(busy), 1);
    i2c_stop();
    chk("busy_mismatch_stop", int'(busy), 0);

    // Pointer wrap 15 -> 0 -> 1
    preload(4'd15, 8'h11); preload(4'd0, 8'h22); preload(4'd1, 8'h33);
    i2c_start();
    wbyte(8'h44, 0, 0); wbyte(8'h0F, 0, 0);
    i2c_start();
    wbyte(8'h45, 0, 0);
    rbyte(8'h11, 1'b0); rbyte(8'h22, 1'b1);
    i2c_stop();
    i2c_start();
    wbyte(8'h45, 0, 0);
    rbyte(8'h33, 1'b1);
    i2c_stop();

    // Reset during bit 4 of a read of 0x00 (slave holding SDA low)
    preload(4'd2, 8'h00);
    i2c_start();
    wbyte(8'h45, 0, 0);
    for (int i = 0; i < 3; i++) begin
      exp_bus.push_back(0); exp_tag.push_back("rst_read_bit");
      bit_in(bv); obs_bus.push_back(int'(bv));
    end
    m_sda = 1'b1; wc(T);
    m_scl = 1'b1; wc(T/2);
    chk("oe_before_rst", int'(sda_oe), 1);
    rst = 1'b1; wc(1); rst = 1'b0;
    chk("oe_after_rst", int'(sda_oe), 0);
    chk("busy_after_rst", int'(busy), 0);
    wc(T/2 - 1);
    m_scl = 1'b0; wc(2);
    i2c_stop();
    exp_wr.push_back('h7C3);
    i2c_start();
    wbyte(8'h44, 0, 0); wbyte(8'h07, 0, 0); wbyte(8'hC3, 0, 0);
    i2c_stop();

    // Preload/bus write collision on address 5
    exp_wr.push_back('h577);
    i2c_start();
    wbyte(8'h44, 0, 0); wbyte(8'h05, 0, 0); wbyte(8'h77, 0, 1);
    i2c_stop();
    i2c_start();
    wbyte(8'h44, 0, 0); wbyte(8'h05, 0, 0);
    i2c_start();
    wbyte(8'h45, 0, 0);
    rbyte(8'h77, 1'b1);
    i2c_stop();

    wc(20);
    chk("exp_wr_drained", exp_wr.size(), 0);
    chk("exp_bus_drained", exp_bus.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
